// File: rtl/muldiv_sequencer_if.sv
// Request/response handshake and borrowed-ALU signals of the multiply/divide sequencer.
// The slave modport is the sequencer side; master is the core/execute side.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            alu_own;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_src_a;
    logic [XLEN-1:0] alu_src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_carry;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_dbz;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_carry,
        output req_ready, alu_own, alu_op, alu_src_a, alu_src_b, rsp_valid, rsp_data, rsp_dbz
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result, alu_carry,
        input  req_ready, alu_own, alu_op, alu_src_a, alu_src_b, rsp_valid, rsp_data, rsp_dbz
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU for one
// shift-add or restoring-divide iteration per cycle.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  flush,
    muldiv_sequencer_if.slave    io
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_dbz_q, rsp_dbz_d;
    logic              alu_own_q, alu_own_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [XLEN-1:0]   alu_src_a_q, alu_src_a_d;
    logic [XLEN-1:0]   alu_src_b_q, alu_src_b_d;
    logic [XLEN-1:0]   div_src_a_s;
    logic              ge_s;
    logic              run_next_s;

    assign io.req_ready = (state_q == IDLE);
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_data  = rsp_data_q;
    assign io.rsp_dbz   = rsp_dbz_q;
    assign io.alu_own   = alu_own_q;
    assign io.alu_op    = alu_op_q;
    assign io.alu_src_a = alu_src_a_q;
    assign io.alu_src_b = alu_src_b_q;

    // Next-state, datapath iteration and precomputed ALU drive for the coming cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_dbz_d   = rsp_dbz_q;
        div_src_a_s = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        // R[MSB] set means the shifted partial remainder already exceeds any divisor.
        ge_s        = hi_q[XLEN-1] | io.alu_carry;

        if (flush) begin
            state_d     = IDLE;
            cnt_d       = {CNT_W{1'b0}};
            rsp_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.req_valid) begin
                        op_d  = io.req_op;
                        hi_d  = {XLEN{1'b0}};
                        lo_d  = io.req_a;
                        b_d   = io.req_b;
                        cnt_d = {CNT_W{1'b0}};
                        if (io.req_op[1] && (io.req_b == {XLEN{1'b0}})) begin
                            state_d     = DONE;
                            rsp_valid_d = 1'b1;
                            rsp_dbz_d   = 1'b1;
                            rsp_data_d  = io.req_op[0] ? io.req_a : {XLEN{1'b1}};
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[1]) begin
                        hi_d = ge_s ? io.alu_result : div_src_a_s;
                        lo_d = {lo_q[XLEN-2:0], ge_s};
                    end else begin
                        {hi_d, lo_d} = {io.alu_carry, io.alu_result, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d     = DONE;
                        rsp_valid_d = 1'b1;
                        rsp_dbz_d   = 1'b0;
                        // MUL/DIVU take the low (product/quotient) half, MULHU/REMU the high.
                        rsp_data_d  = op_q[0] ? hi_d : lo_d;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (io.rsp_ready) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            endcase
        end

        run_next_s = (state_d == RUN);
        alu_own_d  = run_next_s;
        if (run_next_s) begin
            alu_op_d    = op_d[1] ? ALU_SUB : ALU_ADD;
            alu_src_a_d = op_d[1] ? {hi_d[XLEN-2:0], lo_d[XLEN-1]} : hi_d;
            alu_src_b_d = (op_d[1] || lo_d[0]) ? b_d : {XLEN{1'b0}};
        end else begin
            alu_op_d    = ALU_ADD;
            alu_src_a_d = {XLEN{1'b0}};
            alu_src_b_d = {XLEN{1'b0}};
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            hi_q        <= {XLEN{1'b0}};
            lo_q        <= {XLEN{1'b0}};
            b_q         <= {XLEN{1'b0}};
            op_q        <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {XLEN{1'b0}};
            rsp_dbz_q   <= 1'b0;
            alu_own_q   <= 1'b0;
            alu_op_q    <= ALU_ADD;
            alu_src_a_q <= {XLEN{1'b0}};
            alu_src_b_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dbz_q   <= rsp_dbz_d;
            alu_own_q   <= alu_own_d;
            alu_op_q    <= alu_op_d;
            alu_src_a_q <= alu_src_a_d;
            alu_src_b_q <= alu_src_b_d;
        end
    end
endmodule
